// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between instruction fetch (m0)
// and load/store (m1); each access is captured, driven for one cycle, then acked.
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t            state_reg, state_next;
  logic              gnt_reg, gnt_next;
  logic              last_reg, last_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              winner;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    winner     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On contention the requester that did not win last time is served.
          if (m0_req && m1_req) winner = ~last_reg;
          else                  winner = m1_req;
          gnt_next   = winner;
          last_next  = winner;
          we_next    = winner ? m1_we    : m0_we;
          addr_next  = winner ? m1_addr  : m0_addr;
          wdata_next = winner ? m1_wdata : m0_wdata;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!we_reg) rdata_next = ram_rdata;
        state_next = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 1'b0;
      last_reg  <= 1'b1;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  // RAM strobes decode from state alone, so a write already in BUSY commits even under reset.
  assign ram_read  = (state_reg == BUSY) && !we_reg;
  assign ram_write = (state_reg == BUSY) &&  we_reg;
  assign ram_addr  = {2'b00, addr_reg[ADDR_W-1:2]};
  assign ram_wdata = wdata_reg;

  assign m0_ack   = (state_reg == ACK) && !gnt_reg;
  assign m1_ack   = (state_reg == ACK) &&  gnt_reg;
  assign m0_rdata = rdata_reg;
  assign m1_rdata = rdata_reg;

endmodule
